// File: rtl/hello_scroll_ctrl_if.sv
// Control/status bundle between the HELLO scroll sequencer and its board-side logic.
// The sequencer takes the slave view; switch/button logic and display decoders take the master view.
interface hello_scroll_ctrl_if #(
  parameter int NumDisp = 6
);
  logic                   Run;
  logic                   StepBtn;
  logic                   Dir;
  logic [2:0]             Pos;
  logic                   Tick;
  logic                   Wrap;
  logic [1:0]             State;
  logic [3*NumDisp-1:0]   Codes;

  modport master (
    output Run, StepBtn, Dir,
    input  Pos, Tick, Wrap, State, Codes
  );

  modport slave (
    input  Run, StepBtn, Dir,
    output Pos, Tick, Wrap, State, Codes
  );
endinterface

// File: rtl/hello_scroll_ctrl.sv
// HELLO scroll sequencer: prescales clk into scroll steps, owns the 0..7 position,
// and produces per-display character codes for the seven-segment decoders.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset; prescaler held at 0, waits for Run or a step
//   RUN   | free-running; prescaler counts, Pos advances at terminal count
//   PAUSE | Pos and prescaler frozen; button steps advance one position
module hello_scroll_ctrl #(
  parameter int TickDiv = 25_000_000,
  parameter int MsgLen  = 8,
  parameter int NumDisp = 6
) (
  input  logic               Clock,
  input  logic               Clr_n,
  hello_scroll_ctrl_if.slave bus
);

  localparam int POS_W = $clog2(MsgLen);
  localparam int PW    = $clog2(TickDiv);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TickDiv - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               tick_q, wrap_q;
  logic               wrap_d;
  logic               step_q;
  logic               step_req;
  logic               advance;
  logic [3*NumDisp-1:0] codes;

  assign step_req = bus.StepBtn & ~step_q;

  always_ff @(posedge Clock or negedge Clr_n) begin
    if (!Clr_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      pos_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      pos_q   <= pos_d;
      tick_q  <= advance;
      wrap_q  <= wrap_d;
      step_q  <= bus.StepBtn;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (bus.Run) begin
          state_d = RUN;
        end else if (step_req) begin
          advance = 1'b1;
          state_d = PAUSE;
        end
      end
      RUN: begin
        // Dropping Run freezes the count, even at terminal count.
        if (!bus.Run) begin
          state_d = PAUSE;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          advance = 1'b1;
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      PAUSE: begin
        if (bus.Run) begin
          state_d = RUN;
        end else if (step_req) begin
          advance = 1'b1;
          presc_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase
  end

  always_comb begin
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (advance) begin
      if (bus.Dir) begin
        pos_d  = pos_q - 1'b1;
        wrap_d = (pos_q == '0);
      end else begin
        pos_d  = pos_q + 1'b1;
        wrap_d = (pos_q == '1);
      end
    end
  end

  function automatic logic [2:0] char_code(input logic [POS_W-1:0] idx);
    case (idx)
      POS_W'(0): char_code = 3'd0;
      POS_W'(1): char_code = 3'd1;
      POS_W'(2): char_code = 3'd2;
      POS_W'(3): char_code = 3'd2;
      POS_W'(4): char_code = 3'd3;
      default:   char_code = 3'd7;
    endcase
  endfunction

  // Display k (k=NumDisp-1 leftmost) shows message index Pos + (NumDisp-1-k).
  always_comb begin
    codes = '0;
    for (int k = 0; k < NumDisp; k++) begin
      codes[3*k +: 3] = char_code(pos_q + POS_W'(NumDisp - 1 - k));
    end
  end

  assign bus.Pos   = pos_q;
  assign bus.Tick  = tick_q;
  assign bus.Wrap  = wrap_q;
  assign bus.State = state_q;
  assign bus.Codes = codes;

endmodule
